alu_share_arbiter: RTL and testbench

- Shares one combinational `alu_4bit` instance (ports A, B, op, Y, carry_out, overflow, zero, sign) between two requesters using round-robin arbitration.
- Each request is accepted over a valid/ready handshake, executed through an internal operand register, and returned on a single registered response channel tagged with the requester ID.
- Sits between the two datapath clients and the ALU, and is the only block that drives the ALU inputs.

---
 rtl/alu_share_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin share of one 4-bit ALU between two requesters
module alu_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [2:0] op,
  output logic [3:0] Y,
  output logic       carry_out,
  output logic       overflow,
  output logic       zero,
  output logic       sign
);
  logic [4:0] sum;

  // SUB is A + ~B + 1, so carry_out is the no-borrow flag.
  always_comb begin
    sum       = 5'd0;
    Y         = 4'd0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    case (op)
      3'b000: begin
        sum       = {1'b0, A} + {1'b0, B};
        Y         = sum[3:0];
        carry_out = sum[4];
        overflow  = (A[3] == B[3]) && (sum[3] != A[3]);
      end
      3'b001: begin
        sum       = {1'b0, A} + {1'b0, ~B} + 5'd1;
        Y         = sum[3:0];
        carry_out = sum[4];
        overflow  = (A[3] != B[3]) && (sum[3] != A[3]);
      end
      3'b010:  Y = A & B;
      3'b011:  Y = A | B;
      3'b100:  Y = A ^ B;
      default: Y = 4'd0;
    endcase
  end

  assign zero = (Y == 4'd0);
  assign sign = Y[3];
endmodule

module alu_share_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_y,
  output logic             rsp_c,
  output logic             rsp_v,
  output logic             rsp_z,
  output logic             rsp_s,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [3:0]       opa_q, opa_d, opb_q, opb_d;
  logic [2:0]       opc_q, opc_d;
  logic             oid_q, oid_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d;
  logic [3:0]       rsp_y_q, rsp_y_d;
  logic             rsp_c_q, rsp_c_d, rsp_v_q, rsp_v_d;
  logic             rsp_z_q, rsp_z_d, rsp_s_q, rsp_s_d, rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       gnt_id, any_valid, op_illegal;
  logic [2:0] alu_op;
  logic [3:0] alu_y;
  logic       alu_c, alu_v, alu_z, alu_s;

  assign any_valid  = req0_valid | req1_valid;
  assign gnt_id     = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign op_illegal = (opc_q > 3'd4);
  assign alu_op     = op_illegal ? 3'd0 : opc_q;

  alu_4bit u_alu (
    .A(opa_q), .B(opb_q), .op(alu_op), .Y(alu_y),
    .carry_out(alu_c), .overflow(alu_v), .zero(alu_z), .sign(alu_s)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    opc_d       = opc_q;
    oid_d       = oid_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_c_d     = rsp_c_q;
    rsp_v_d     = rsp_v_q;
    rsp_z_d     = rsp_z_q;
    rsp_s_d     = rsp_s_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = rst_n && req0_valid && !gnt_id;
        req1_ready = rst_n && req1_valid && gnt_id;
        if (any_valid) begin
          opa_d   = gnt_id ? req1_a  : req0_a;
          opb_d   = gnt_id ? req1_b  : req0_b;
          opc_d   = gnt_id ? req1_op : req0_op;
          oid_d   = gnt_id;
          ptr_d   = ~gnt_id;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d    = oid_q;
        rsp_y_d     = op_illegal ? 4'd0 : alu_y;
        rsp_c_d     = op_illegal ? 1'b0 : alu_c;
        rsp_v_d     = op_illegal ? 1'b0 : alu_v;
        rsp_z_d     = op_illegal ? 1'b1 : alu_z;
        rsp_s_d     = op_illegal ? 1'b0 : alu_s;
        rsp_err_d   = op_illegal;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      opa_q       <= 4'd0;
      opb_q       <= 4'd0;
      opc_q       <= 3'd0;
      oid_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_y_q     <= 4'd0;
      rsp_c_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_s_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      opc_q       <= opc_d;
      oid_q       <= oid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_c_q     <= rsp_c_d;
      rsp_v_q     <= rsp_v_d;
      rsp_z_q     <= rsp_z_d;
      rsp_s_q     <= rsp_s_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_v     = rsp_v_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed vector bench for alu_share_arbiter
module tb_alu_share_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_y;
  logic       rsp_c, rsp_v, rsp_z, rsp_s, rsp_err;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_z(rsp_z), .rsp_s(rsp_s), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  typedef struct {
    bit         id;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] y;
    bit         c, v, z, s, e;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  task automatic drive(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Drives one request, waits for its accept, and returns at the negedge where the response is up.
  task automatic issue(input bit id, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    bit got = 1'b0;
    @(negedge clk);
    drive(id, a, b, op);
    #1;
    for (int n = 0; n < 10; n++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    chk("accept_timeout", got, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = 4'($urandom); req0_b = 4'($urandom); req0_op = 3'($urandom);
    req1_a = 4'($urandom); req1_b = 4'($urandom); req1_op = 3'($urandom);
    @(negedge clk);
    chk("lat_exec_no_valid", rsp_valid, 0);
    @(negedge clk);
    chk("lat_resp_valid", rsp_valid, 1);
  endtask

  task automatic check_rsp(input string tag, input vec_t t);
    chk({tag, "_id"}, rsp_id, t.id);
    chk({tag, "_y"}, rsp_y, t.y);
    chk({tag, "_cvzs"}, {rsp_c, rsp_v, rsp_z, rsp_s}, {t.c, t.v, t.z, t.s});
    chk({tag, "_err"}, rsp_err, t.e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 4'h7, 4'h1, 3'b000, 4'h8, 0, 1, 0, 1, 0};
    vecs[1] = '{1, 4'h3, 4'h5, 3'b001, 4'hE, 0, 0, 0, 1, 0};
    vecs[2] = '{0, 4'hC, 4'hA, 3'b010, 4'h8, 0, 0, 0, 1, 0};
    vecs[3] = '{1, 4'h5, 4'h2, 3'b011, 4'h7, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 4'h6, 4'h6, 3'b100, 4'h0, 0, 0, 1, 0, 0};
    vecs[5] = '{0, 4'h9, 4'h2, 3'b111, 4'h0, 0, 0, 1, 0, 1};
    vecs[6] = '{1, 4'hF, 4'hF, 3'b101, 4'h0, 0, 0, 1, 0, 1};
    vecs[7] = '{0, 4'hF, 4'h1, 3'b000, 4'h0, 1, 0, 1, 0, 0};
    vecs[8] = '{1, 4'h8, 4'h1, 3'b001, 4'h7, 1, 1, 0, 0, 0};
    vecs[9] = '{0, 4'h8, 4'h8, 3'b000, 4'h0, 1, 1, 1, 0, 0};

    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 4'h1; req1_b = 4'h1; req1_op = 3'b000;
    repeat (3) @(negedge clk);
    chk("reset_ready", {req0_ready, req1_ready}, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_fields", {rsp_id, rsp_y, rsp_c, rsp_v, rsp_z, rsp_s, rsp_err}, 0);
    chk("reset_op_count", op_count, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      check_rsp($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
      exp_count++;
      chk("vec_done_valid", rsp_valid, 0);
      chk("vec_op_count", op_count, exp_count);
    end

    // Backpressure: response must hold and no new grant while pending.
    rsp_ready = 1'b0;
    issue(0, 4'h2, 4'h3, 3'b000);
    drive(0, 4'h1, 4'h1, 3'b000);
    drive(1, 4'h1, 4'h1, 3'b000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_y", {rsp_id, rsp_y, rsp_z, rsp_err}, {1'b0, 4'h5, 1'b0, 1'b0});
      chk("stall_ready", {req0_ready, req1_ready}, 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_count++;
    chk("stall_release_valid", rsp_valid, 0);
    chk("stall_op_count", op_count, exp_count);

    // Round-robin alternation with both requesters always valid.
    do_reset();
    drive(0, 4'hF, 4'hF, 3'b100);
    drive(1, 4'h0, 4'h0, 3'b011);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("alt_ready_any", req0_ready | req1_ready, 1);
      chk("alt_grant", req1_ready, k % 2);
      chk("alt_exclusive", req0_ready & req1_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("alt_exec_ready", {req0_ready, req1_ready, rsp_valid}, 0);
      @(negedge clk);
      chk("alt_rsp_valid", rsp_valid, 1);
      chk("alt_rsp_id", rsp_id, k % 2);
      chk("alt_rsp_yz", {rsp_y, rsp_z}, {4'h0, 1'b1});
      @(negedge clk);
      #1;
      exp_count++;
      chk("alt_op_count", op_count, exp_count);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset during EXEC after a req0 grant moved the pointer to requester 1.
    @(negedge clk);
    drive(0, 4'h4, 4'h4, 3'b000);
    #1;
    chk("rstx_accept", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 4'h1, 4'h2, 3'b000);
    drive(1, 4'h3, 4'h3, 3'b000);
    #1;
    chk("rstx_ready_low", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    chk("rstx_rsp_valid", rsp_valid, 0);
    chk("rstx_op_count", op_count, 0);
    rst_n = 1'b1;
    exp_count = 0;
    #1;
    chk("rstx_grant_req0", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstx_rsp", {rsp_valid, rsp_id, rsp_y}, {1'b1, 1'b0, 4'h3});
    @(negedge clk);

    // Saturation of the completion counter.
    do_reset();
    drive(0, 4'h1, 4'h1, 3'b000);
    repeat (765) @(posedge clk);
    @(negedge clk);
    chk("sat_reach", op_count, 8'hFF);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("sat_hold", op_count, 8'hFF);
    req0_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
